fetch_sequencer: RTL
====================

# fetch_sequencer

Controls the single-core fetch stage. Generates `pcnext` for the program counter register every cycle, drives a request/ready handshake to instruction memory, holds the fetched instruction for decode, and applies branch/jump redirects and trap entry. It sits between the program counter register, instruction memory and the decode/execute stages.

## Interface

- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0100: fetch address on trap entry.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from the program counter register.
- `pcnext`  out  32  next PC to the program counter register; that register loads it every clock.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equal to `pc`.
- `imem_ready`  in  1  instruction memory data is valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction for decode.
- `instr_valid`  out  1  `instr` is valid and being offered.
- `stall`  in  1  decode cannot accept `instr` this cycle.
- `redirect`  in  1  taken branch or jump for the instruction being offered.
- `redirect_target`  in  32  target address for `redirect`.
- `trap`  in  1  trap or interrupt request.
- `fault`  out  1  sticky misaligned-target flag.
- `instr_count`  out  32  number of instructions retired from ISSUE.

## Operation

- States: BOOT, FETCH, ISSUE, FAULT.
- BOOT: `imem_req`=0 and `pcnext`=RESET_VECTOR. Moves unconditionally to FETCH.
- FETCH:
  - `imem_req`=1 and `pcnext`=`pc` (hold).
  - `trap` sets the pending-trap flag.
  - On `imem_ready` with no trap pending and no `trap` this cycle: capture `imem_rdata` into `instr`, then go to ISSUE.
  - On `imem_ready` with a trap pending or `trap` this cycle: discard the data, set `pcnext`=TRAP_VECTOR, clear the flag, stay in FETCH.
  - `redirect` is ignored in FETCH.
- ISSUE: `instr_valid`=1, `imem_req`=0. Priority per cycle:
  1. `trap`: `pcnext`=TRAP_VECTOR, go to FETCH. The instruction is not counted.
  2. `redirect` with `redirect_target[1:0]`≠0: go to FAULT, set `fault`, `pcnext`=`pc`. This is checked regardless of `stall`.
  3. `redirect`: `pcnext`=`redirect_target`, `instr_count`+1, go to FETCH. Accepted even when `stall`=1.
  4. `stall`=0: `pcnext`=`pc`+4, `instr_count`+1, go to FETCH.
  5. Otherwise: hold, `pcnext`=`pc`, and `instr` stays stable.
- FAULT: `pcnext`=`pc`, `imem_req`=0, `instr_valid`=0, `fault`=1. Only `rst` leaves FAULT.
- Arithmetic: `pc`+4 wraps modulo 2^32 (32'hFFFF_FFFC goes to 0). `instr_count` wraps modulo 2^32.
- Reset values: state=BOOT, `instr`=32'h0000_0013 (NOP), pending-trap=0, `fault`=0, `instr_count`=0.
  - Hence after reset: `pcnext`=RESET_VECTOR, `imem_req`=0, `instr_valid`=0.

## Timing

- `pcnext`, `imem_req`, `imem_addr` and `instr_valid` are combinational from state and inputs. `instr`, `fault` and `instr_count` are registered.
- Minimum of 2 cycles per instruction when `imem_ready` is high in the first FETCH cycle. Each extra wait cycle on `imem_ready` adds one cycle.
- `pc` takes the new value at the edge that ends ISSUE, which is the same edge as the FETCH transition.
- First fetch: reset deasserts, BOOT lasts 1 cycle, and `pc`=RESET_VECTOR in the first FETCH cycle.
- `rst` asserted mid-handshake aborts immediately. Outstanding memory data is ignored after reset.
- `trap` and `imem_ready` in the same FETCH cycle: the trap wins and the data is dropped.
- `trap` and `redirect` in the same ISSUE cycle: the trap wins.

## Structure

- Shared package: the state enum (BOOT/FETCH/ISSUE/FAULT), the NOP constant 32'h0000_0013, and the PC increment constant 4.
- Single module; no sub-module is required.
- An optional `pc_incrementer` sub-module may be used for the +4 adder so that it can be reused by link-address logic.

## Test plan

- Reset, then `imem_ready` tied to 1 with no stalls. Required: `pc` sequence 0, 4, 8, 12 at 2 cycles each; `instr_count`=4 after 8 cycles in FETCH/ISSUE.
- `imem_ready` delayed 3 cycles on the fetch at 0x8. Required: `imem_req` held high for 4 cycles and `pc` stable at 0x8; the instruction is then issued.
- `stall` held 5 cycles in ISSUE at `pc`=0x10. Required: `instr` and `pc` stable for 5 cycles, `instr_count` unchanged, then `pc`=0x14.
- `redirect`=1 with `redirect_target`=0x200 while `stall`=1 at `pc`=0x20. Required: next `pc`=0x200 and `instr_count`+1.
- `trap` during a FETCH wait, with `imem_ready` arriving 2 cycles later. Required: data discarded, `instr_valid` never high, next `pc`=0x100.
- `redirect_target`=0x202. Required: `fault`=1 and `pc` frozen; `rst` clears `fault` and restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } state_t;

  // addi x0, x0, 0 -- harmless instruction presented before the first fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_sequencer_pc_incrementer.sv
// Sequential-PC adder, kept separate so link-address logic can reuse it.
// Latency: combinational.
// Backpressure: none.
//   pc       : current program counter
//   pc_plus4 : pc + 4, wrapping modulo 2^32
module pc_incrementer
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + PC_INCR;

endmodule

// File: rtl/fetch_sequencer.sv
// Single-core fetch control: drives pcnext, the imem handshake, the decode
// hand-off, redirects and trap entry.
// Latency: 2 cycles per instruction minimum (FETCH + ISSUE), +1 per imem wait.
// Backpressure: stall holds ISSUE with instr stable; redirect is taken even when stalled.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   pc / pcnext      : external PC register value / value it loads every clock
//   imem_req/addr    : fetch request and address (addr is always pc)
//   imem_ready/rdata : instruction memory response
//   instr/valid      : held instruction offered to decode; stall from decode
//   redirect(_target): taken branch/jump for the offered instruction
//   trap             : trap or interrupt request
//   fault            : sticky misaligned-redirect flag
//   instr_count      : instructions retired from ISSUE
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pcnext,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  output logic        fault,
  output logic [31:0] instr_count
);

  state_t      state;
  logic        trap_pend;
  logic [31:0] pc_plus4;
  logic        trap_hit;
  logic        bad_target;

  pc_incrementer u_pc_inc (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // A trap seen during any wait cycle of the fetch is remembered, so the
  // eventual memory response is dropped rather than issued.
  assign trap_hit   = trap_pend | trap;
  assign bad_target = (redirect_target[1:0] != 2'b00);
  assign imem_addr  = pc;

  always_comb begin
    pcnext      = pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      BOOT: pcnext = RESET_VECTOR;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && trap_hit) pcnext = TRAP_VECTOR;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (trap)                        pcnext = TRAP_VECTOR;
        else if (redirect && bad_target) pcnext = pc;
        else if (redirect)               pcnext = redirect_target;
        else if (!stall)                 pcnext = pc_plus4;
      end
      FAULT: pcnext = pc;
      default: pcnext = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      instr       <= NOP_INSTR;
      trap_pend   <= 1'b0;
      fault       <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            if (trap_hit) begin
              // Response discarded; pcnext already steers to the trap vector.
              trap_pend <= 1'b0;
            end else begin
              instr <= imem_rdata;
              state <= ISSUE;
            end
          end else if (trap) begin
            trap_pend <= 1'b1;
          end
        end
        ISSUE: begin
          if (trap) begin
            state <= FETCH;
          end else if (redirect && bad_target) begin
            fault <= 1'b1;
            state <= FAULT;
          end else if (redirect || !stall) begin
            instr_count <= instr_count + 32'd1;
            state       <= FETCH;
          end
        end
        FAULT: fault <= 1'b1;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
